// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM states and memory size for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int MEM_WORDS_DEF = 16384;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - combinational load lane extract/extend and sub-word store merge
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{off, 3'b000} +: 8];
        half_sel = off[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = word;
        endcase

        // Only the addressed lane changes; the rest of the old word is kept.
        merged = word;
        case (funct3)
            F3_B:    merged[{off, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// rtl/lsu_mem_initiator.sv - RV32I load/store unit in front of a word-only data memory
// Define LSU_MISALIGN_TRAP_EN to report misaligned H/W accesses as errors instead of aligning them.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_WORDS);

    lsu_state_t        state, state_nxt;
    logic [ADDR_W-1:0] a_addr;
    logic [2:0]        a_f3;
    logic [31:0]       wd_q;
    logic [31:0]       load_data, merged;
    logic              accept, is_h, is_w, f3_ok, oor, req_err;
    logic [ADDR_W-1:0] addr_al;

    assign req_ready = (state == IDLE) && rst;
    assign accept    = req_valid && req_ready;

    assign is_h  = (req_funct3 == F3_H) || (req_funct3 == F3_HU);
    assign is_w  = (req_funct3 == F3_W);
    assign f3_ok = req_store ? (req_funct3 inside {F3_B, F3_H, F3_W})
                             : (req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign oor   = {2'b00, req_addr[ADDR_W-1:2]} >= MEM_LIMIT;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_err = !f3_ok || oor || (is_h && req_addr[0]) || (is_w && (req_addr[1:0] != 2'b00));
    assign addr_al = req_addr;
`else
    assign req_err = !f3_ok || oor;
    assign addr_al = {req_addr[ADDR_W-1:2], is_w ? 2'b00 : {req_addr[1], req_addr[0] && !is_h}};
`endif

    lsu_lane_align u_align (
        .word      (mem_rd),
        .off       (a_addr[1:0]),
        .funct3    (a_f3),
        .wdata     (wd_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wd    = 32'h0;
        case (state)
            IDLE: begin
                if (accept && !req_err) begin
                    state_nxt = !req_store ? LOAD : ((req_funct3 == F3_W) ? WRITE : RMW_RD);
                end
            end
            LOAD:    state_nxt = IDLE;
            RMW_RD:  state_nxt = WRITE;
            WRITE: begin
                state_nxt = IDLE;
                mem_we    = 1'b1;
                mem_wd    = wd_q;
            end
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE) begin
            mem_addr = {a_addr[ADDR_W-1:2], 2'b00};
        end
    end

    // wd_q carries the store data until RMW_RD overwrites it with the merged word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_addr     <= '0;
            a_f3       <= F3_B;
            wd_q       <= 32'h0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            if (accept) begin
                a_addr     <= addr_al;
                a_f3       <= req_funct3;
                wd_q       <= req_wdata;
                resp_valid <= req_err;
                resp_err   <= req_err;
            end
            case (state)
                LOAD: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= load_data;
                end
                RMW_RD:  wd_q <= merged;
                WRITE:   resp_valid <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb/tb_lsu_mem_initiator.sv - randomized self-checking bench for lsu_mem_initiator
module tb_lsu_mem_initiator;

    localparam int MW = 16384;
    localparam int NC = 4096;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        req_valid  = 1'b0;
    logic        req_store  = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr   = 32'h0;
    logic [31:0] req_wdata  = 32'h0;
    logic        req_ready, resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wd, mem_rd;

    logic [31:0] mem     [MW];
    logic [31:0] ref_mem [MW];

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    bit          exp_busy [NC];
    bit          exp_rv   [NC];
    bit          exp_er   [NC];
    bit          exp_we   [NC];
    logic [31:0] exp_rd   [NC];
    logic [31:0] exp_wd   [NC];
    logic [31:0] exp_ma   [NC];

    logic [31:0] last_rdata    = 32'h0;
    logic        last_err      = 1'b0;
    int          last_resp_cyc = -1;
    int          we_cnt        = 0;
    int          last_we_cyc   = -1;

    lsu_mem_initiator #(.ADDR_W(32), .MEM_WORDS(MW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_we) mem[mem_addr[15:2]] <= mem_wd;
    assign mem_rd = (mem_addr[31:16] == 16'h0) ? mem[mem_addr[15:2]] : 32'h0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkint(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the expectation tables filled by the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk1("req_ready", req_ready, !exp_busy[cyc]);
            chk1("resp_valid", resp_valid, exp_rv[cyc]);
            chk1("mem_we", mem_we, exp_we[cyc]);
            chk32("mem_addr", mem_addr, exp_busy[cyc] ? exp_ma[cyc] : 32'h0);
            chk32("mem_wd", mem_wd, exp_we[cyc] ? exp_wd[cyc] : 32'h0);
            if (exp_rv[cyc]) begin
                chk1("resp_err", resp_err, exp_er[cyc]);
                chk32("resp_rdata", resp_rdata, exp_rd[cyc]);
            end
        end
        if (resp_valid) begin
            last_rdata    = resp_rdata;
            last_err      = resp_err;
            last_resp_cyc = cyc;
        end
        if (mem_we) begin
            we_cnt++;
            last_we_cyc = cyc;
        end
    end

    // Request-level reference: latency, error, load value and the memory word after a store.
    function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a_in,
                                  input logic [31:0] wd, output int lat, output bit er,
                                  output logic [31:0] rd, output logic [31:0] ma, output logic [31:0] nw);
        int          sz, sh;
        logic [31:0] a, w, v, mask;
        bit          legal, oor;
        a     = a_in;
        sz    = (f3[1:0] == 2'd2) ? 4 : ((f3[1:0] == 2'd1) ? 2 : 1);
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        oor   = (a / 4) >= MW;
`ifdef LSU_MISALIGN_TRAP_EN
        er = !legal || oor || ((a % sz) != 0);
`else
        er = !legal || oor;
        a  = a - (a % sz);
`endif
        rd  = 32'h0;
        nw  = 32'h0;
        ma  = a & 32'hFFFF_FFFC;
        lat = 1;
        if (er) return;
        w  = ref_mem[a[15:2]];
        sh = 8 * (a % 4);
        if (!st) begin
            lat = 2;
            if (sz == 4) begin
                rd = w;
            end else begin
                v  = (w >> sh) & ((sz == 1) ? 32'hFF : 32'hFFFF);
                rd = (!f3[2] && v[8*sz-1]) ? (v | ((sz == 1) ? 32'hFFFF_FF00 : 32'hFFFF_0000)) : v;
            end
        end else begin
            lat  = (sz == 4) ? 2 : 3;
            mask = (sz == 4) ? 32'hFFFF_FFFF : (((sz == 1) ? 32'hFF : 32'hFFFF) << sh);
            nw   = (w & ~mask) | ((wd << sh) & mask);
            ref_mem[a[15:2]] = nw;
        end
    endfunction

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        if (exp_busy[cyc]) begin
            req_valid  = 1'($urandom);
            req_store  = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
        end else begin
            req_valid = 1'b0;
        end
    endtask

    task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output bit er, output logic [31:0] rd, output int at);
        logic [31:0] ma, nw;
        int          guard;
        guard = 0;
        while (exp_busy[cyc] && guard < 8) begin
            idle_cycle();
            guard++;
        end
        if (cyc + 8 >= NC) begin
            $display("FAIL cycle_budget: cycle %0d reached table limit %0d", cyc, NC);
            $fatal(1);
        end
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        model(st, f3, a, wd, lat, er, rd, ma, nw);
        at = cyc;
        for (int c = cyc + 1; c < cyc + lat; c++) begin
            exp_busy[c] = 1'b1;
            exp_ma[c]   = ma;
        end
        exp_rv[cyc + lat] = 1'b1;
        exp_er[cyc + lat] = er;
        exp_rd[cyc + lat] = rd;
        if (st && !er) begin
            exp_we[cyc + lat - 1] = 1'b1;
            exp_wd[cyc + lat - 1] = nw;
        end
        idle_cycle();
    endtask

    task automatic wait_resp(input int at, input int lat);
        int guard;
        guard = 0;
        while (cyc < at + lat && guard < 16) begin
            idle_cycle();
            guard++;
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int          lat, at, at2, we0, rc0;
        bit          er;
        logic [31:0] rd;
        bit          e_st   [3];
        logic [2:0]  e_f3   [3];
        logic [31:0] e_addr [3];

        for (int i = 0; i < MW; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[16] = 32'h8899AABB; ref_mem[16] = 32'h8899AABB;
        mem[17] = 32'h11223344; ref_mem[17] = 32'h11223344;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_req_ready", req_ready, 1'b0);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk1("rst_resp_err", resp_err, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk32("rst_resp_rdata", resp_rdata, 32'h0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wd", mem_wd, 32'h0);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        chk_en = 1'b1;

        issue(1'b0, 3'b000, 32'h41, 32'h0, lat, er, rd, at);
        chk32("model_lb", rd, 32'hFFFF_FFAA);
        wait_resp(at, lat);
        chk32("lb_rdata", last_rdata, 32'hFFFF_FFAA);
        chkint("lb_latency", last_resp_cyc - at, 2);
        chk1("lb_err", last_err, 1'b0);

        issue(1'b0, 3'b100, 32'h41, 32'h0, lat, er, rd, at);
        wait_resp(at, lat);
        chk32("lbu_rdata", last_rdata, 32'h0000_00AA);

        issue(1'b0, 3'b001, 32'h42, 32'h0, lat, er, rd, at);
        wait_resp(at, lat);
        chk32("lh_rdata", last_rdata, 32'hFFFF_8899);

        we0 = we_cnt;
        issue(1'b1, 3'b000, 32'h43, 32'h123456CC, lat, er, rd, at);
        wait_resp(at, lat);
        chk32("sb_mem", mem[16], 32'hCC99_AABB);
        chkint("sb_we_count", we_cnt - we0, 1);
        chkint("sb_we_cycle", last_we_cyc - at, 2);
        chkint("sb_resp_cycle", last_resp_cyc - at, 3);

        issue(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, lat, er, rd, at);
        issue(1'b0, 3'b010, 32'h100, 32'h0, lat, er, rd, at2);
        chkint("b2b_accept_cycle", at2 - at, 2);
        wait_resp(at2, lat);
        chk32("b2b_lw_rdata", last_rdata, 32'hDEAD_BEEF);

        we0 = we_cnt;
        issue(1'b0, 3'b010, 32'h102, 32'h0, lat, er, rd, at);
        wait_resp(at, lat);
`ifdef LSU_MISALIGN_TRAP_EN
        chk1("lw_mis_err", last_err, 1'b1);
        chk32("lw_mis_rdata", last_rdata, 32'h0);
`else
        chk1("lw_mis_err", last_err, 1'b0);
        chk32("lw_mis_rdata", last_rdata, 32'hDEAD_BEEF);
`endif
        chkint("lw_mis_we", we_cnt - we0, 0);

        e_st[0] = 1'b0; e_f3[0] = 3'b011; e_addr[0] = 32'h40;
        e_st[1] = 1'b1; e_f3[1] = 3'b100; e_addr[1] = 32'h40;
        e_st[2] = 1'b0; e_f3[2] = 3'b010; e_addr[2] = MW * 4;
        for (int k = 0; k < 3; k++) begin
            we0 = we_cnt;
            issue(e_st[k], e_f3[k], e_addr[k], 32'hFFFF_FFFF, lat, er, rd, at);
            chk1("model_err", er, 1'b1);
            wait_resp(at, lat);
            chk1("err_flag", last_err, 1'b1);
            chk32("err_rdata", last_rdata, 32'h0);
            chkint("err_latency", last_resp_cyc - at, 1);
            chkint("err_no_write", we_cnt - we0, 0);
        end

        // Reset lands on the WRITE edge of an SH: the write still happens, the response does not.
        rc0 = last_resp_cyc;
        issue(1'b1, 3'b001, 32'h46, 32'hABCD_BEEF, lat, er, rd, at);
        idle_cycle();
        rst    = 1'b0;
        chk_en = 1'b0;
        @(negedge clk);
        chk1("rstw_mem_we", mem_we, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk1("rstw_req_ready", req_ready, 1'b0);
        chk1("rstw_resp_valid", resp_valid, 1'b0);
        chk1("rstw_resp_err", resp_err, 1'b0);
        chk1("rstw_mem_we_off", mem_we, 1'b0);
        chk32("rstw_resp_rdata", resp_rdata, 32'h0);
        chk32("rstw_mem_addr", mem_addr, 32'h0);
        chk32("rstw_mem_wd", mem_wd, 32'h0);
        chk32("rstw_mem_written", mem[17], 32'hBEEF_3344);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 1'b0;
        chk_en    = 1'b1;
        @(negedge clk);
        #1;
        chkint("rstw_no_resp", last_resp_cyc, rc0);
        issue(1'b0, 3'b010, 32'h44, 32'h0, lat, er, rd, at);
        wait_resp(at, lat);
        chk32("rstw_fresh_lw", last_rdata, 32'hBEEF_3344);

        for (int n = 0; n < 250; n++) begin
            bit          st;
            logic [2:0]  f3;
            logic [31:0] idx, a;
            int          r, lf;
            st = 1'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                f3 = 3'($urandom);
            end else begin
                lf = $urandom_range(0, st ? 2 : 4);
                f3 = 3'((lf <= 2) ? lf : lf + 1);
            end
            r = $urandom_range(0, 19);
            if (r < 16)       idx = 32'(16 + r);
            else if (r == 16) idx = 32'd64;
            else if (r == 17) idx = 32'(MW - 1);
            else if (r == 18) idx = 32'(MW + $urandom_range(0, 3));
            else              idx = 32'h3FFF_FFFF;
            a = (idx << 2) | 32'($urandom_range(0, 3));
            issue(st, f3, a, $urandom, lat, er, rd, at);
            if ($urandom_range(0, 1) == 1) wait_resp(at, lat);
        end
        repeat (5) idle_cycle();

        for (int i = 16; i < 32; i++) chk32("final_mem", mem[i], ref_mem[i]);
        chk32("final_mem64", mem[64], ref_mem[64]);
        chk32("final_mem_top", mem[MW-1], ref_mem[MW-1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store unit between the pipeline MEM stage and the word-only data memory (combinational read, single-word write on clk rising edge, word index = A[31:2]).
- Accepts RV32I load/store requests: LB/LH/LW/LBU/LHU, SB/SH/SW.
- Performs byte-lane extraction and sign/zero extension for loads.
- Memory has no byte enables, so sub-word stores are done as read-modify-write.
- Holds the pipeline via req_ready while a request is in flight.

Parameters:
- ADDR_W, 32, byte-address width.
- MEM_WORDS, 16384, number of words in data memory; any word index >= MEM_WORDS is out of range.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned, illegal funct3 or out of range.
- mem_addr  out  ADDR_W  word-aligned byte address {addr[ADDR_W-1:2],2'b00}.
- mem_we  out  1  memory write enable.
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory read data, combinational from mem_addr.

Behaviour:
- States: IDLE, LOAD, RMW_RD, WRITE.
- Request capture: accepted when req_valid && req_ready at a clk edge. addr, funct3, store and wdata are registered. Inputs are ignored at all other times.
- Error check at accept: a request is an error if any of these hold:
  - funct3 is not legal for its direction (loads: 000, 001, 010, 100, 101; stores: 000, 001, 010);
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[ADDR_W-1:2] >= MEM_WORDS.
- Error request: stays in IDLE with no memory access. resp_valid=1, resp_err=1 and resp_rdata=0 in the next cycle.
- Load: IDLE -> LOAD (1 cycle, mem_addr driven). The lane is selected from mem_rd by addr[1:0] and extended (LB/LH sign, LBU/LHU zero), then registered. Returns to IDLE; resp_valid pulses in the cycle after LOAD. Accept-to-resp_valid = 2 cycles.
- SW: IDLE -> WRITE. In WRITE: mem_we=1 and mem_wd=wdata. resp_valid pulses in the next cycle (2 cycles total).
- SB/SH: IDLE -> RMW_RD -> WRITE.
  - RMW_RD: mem_rd is captured and the byte/halfword lane at addr[1:0] is replaced with wdata[7:0] or wdata[15:0].
  - WRITE: the merged word is written.
  - resp_valid pulses in the next cycle (3 cycles total).
- Registered outputs: resp_valid, resp_rdata and resp_err are registered.
- Decoded outputs: mem_we is decoded from state (WRITE only). mem_addr holds the captured address in LOAD, RMW_RD and WRITE, and is 0 in IDLE. mem_wd is 0 outside WRITE.
- Back-to-back: a new request may be accepted in the same cycle resp_valid is high (state is IDLE). The next access starts the following cycle.
- Reset:
  - While rst=0: state=IDLE, req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wd=0.
  - Reset sampled at an edge while in WRITE: the memory still performs that edge's write. No resp_valid is issued afterwards.
  - Reset in LOAD or RMW_RD: the request is dropped with no write.
- Addresses never wrap. The out-of-range check uses the full word index.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned halfword/word requests complete as errors, as described above.
- Undefined: the low address bits are forced to natural alignment (LH/LHU/SH clear addr[0]; LW/SW clear addr[1:0]) and the access proceeds normally. Only illegal funct3 and out-of-range requests raise resp_err.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum lsu_state_t {IDLE, LOAD, RMW_RD, WRITE};
  - MEM_WORDS default.
- One natural sub-module: lsu_lane_align, purely combinational. It does load extraction/extension and store lane merge from (word, addr[1:0], funct3, wdata).

Test Plan:
- Memory word 0x40 preloaded with 0x8899AABB. LB @0x41 -> resp_rdata=0xFFFFFFAA; LBU @0x41 -> 0x000000AA; LH @0x42 -> 0xFFFF8899. resp_valid 2 cycles after accept, resp_err=0.
- SB wdata 0x123456CC @0x43 onto 0x8899AABB -> memory holds 0xCC99AABB. mem_we high exactly 1 cycle, in cycle 2. resp_valid in cycle 3.
- SW 0xDEADBEEF @0x100, then back-to-back LW @0x100 accepted in the resp cycle -> resp_rdata=0xDEADBEEF.
- With LSU_MISALIGN_TRAP_EN: LW @0x102 -> resp_err=1, resp_rdata=0, mem_we never asserted. Without it: LW @0x102 returns the word at 0x100.
- Error cases -> resp_err=1 after 1 cycle, no memory access:
  - funct3=3'b011 load;
  - store with funct3=3'b100;
  - LW @ MEM_WORDS*4.
- Drive rst=0 during the WRITE of an SH -> next cycle all outputs 0 and no resp_valid. After release, req_ready=1 and a fresh LW works.
